// File: rtl/line_steer_ctrl_pkg.sv
// Shared constants for the line-follower steering path: sensor weights, servo scaling,
// default loop gains and the control FSM encoding.
package line_steer_ctrl_pkg;

    // Servo word scaling: 10 us per LSB at 100 MHz, 150 = 1.5 ms neutral pulse.
    localparam int unsigned FRAME_CYCLES_DEF = 2_000_000;
    localparam int unsigned NEUTRAL_DEF      = 150;
    localparam int unsigned SPAN_DEF         = 50;
    localparam int unsigned BASE_SPEED_DEF   = 30;
    localparam int unsigned KP_DEF           = 8;
    localparam int unsigned KD_DEF           = 4;
    localparam int unsigned LOST_FRAMES_DEF  = 25;

    // Sensor weights, bit 4 (leftmost) .. bit 0 (rightmost); positive = line to the right.
    localparam logic signed [3:0] W_BIT4 = -4'sd4;
    localparam logic signed [3:0] W_BIT3 = -4'sd2;
    localparam logic signed [3:0] W_BIT2 = 4'sd0;
    localparam logic signed [3:0] W_BIT1 = 4'sd2;
    localparam logic signed [3:0] W_BIT0 = 4'sd4;

    // Search heading magnitude while the line is lost.
    localparam logic signed [3:0] ERR_SEARCH = 4'sd4;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StDecode,
        StMult,
        StApply
    } steer_state_e;

    // Error for two adjacent lit sensors: mean of their weights.
    function automatic logic signed [3:0] pair_err(input logic signed [3:0] a,
                                                   input logic signed [3:0] b);
        logic signed [3:0] sum;
        sum = a + b;
        return sum >>> 1;
    endfunction

    // Saturate a wheel command to +/- span.
    function automatic logic signed [10:0] clamp_span(input logic signed [10:0] v,
                                                      input logic signed [10:0] span);
        if (v > span) begin
            return span;
        end else if (v < -span) begin
            return -span;
        end
        return v;
    endfunction

endpackage

// File: rtl/line_err_decode.sv
// Maps the 5-bit sensor pattern to a signed line error; patterns that are not a single
// sensor or an adjacent pair (intersections, noise) hold the previous error.
module line_err_decode
    import line_steer_ctrl_pkg::*;
(
    input  logic [4:0]        pattern,
    input  logic signed [3:0] err_prev,
    output logic signed [3:0] err,
    output logic              lost_flag
);

    // Pattern decode; default holds the previous error.
    always_comb begin
        err       = err_prev;
        lost_flag = 1'b0;
        unique case (pattern)
            5'b00000: begin
                err       = 4'sd0;
                lost_flag = 1'b1;
            end
            5'b10000: err = W_BIT4;
            5'b01000: err = W_BIT3;
            5'b00100: err = W_BIT2;
            5'b00010: err = W_BIT1;
            5'b00001: err = W_BIT0;
            5'b11000: err = pair_err(W_BIT4, W_BIT3);
            5'b01100: err = pair_err(W_BIT3, W_BIT2);
            5'b00110: err = pair_err(W_BIT2, W_BIT1);
            5'b00011: err = pair_err(W_BIT1, W_BIT0);
            default:  err = err_prev;
        endcase
    end

endmodule

// File: rtl/line_steer_ctrl.sv
// PD steering controller: samples the synchronised IR bar once per frame, computes a
// clamped differential wheel command and drives the left/right servo position words.
module line_steer_ctrl
    import line_steer_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int unsigned NEUTRAL      = NEUTRAL_DEF,
    parameter int unsigned SPAN         = SPAN_DEF,
    parameter int unsigned BASE_SPEED   = BASE_SPEED_DEF,
    parameter int unsigned KP           = KP_DEF,
    parameter int unsigned KD           = KD_DEF,
    parameter int unsigned LOST_FRAMES  = LOST_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [4:0] sensors,
    output logic [7:0] servo_L,
    output logic [7:0] servo_R,
    output logic       frame_tick,
    output logic       lost
);

    localparam int CntW = $clog2(FRAME_CYCLES);
    localparam int LcW  = $clog2(LOST_FRAMES + 2);

    localparam logic [CntW-1:0]  CntLast = CntW'(FRAME_CYCLES - 1);
    localparam logic [LcW-1:0]   LcLimit = LcW'(LOST_FRAMES);
    localparam logic [LcW-1:0]   LcSat   = LcW'(LOST_FRAMES + 1);
    localparam logic signed [9:0]  KpS   = 10'(KP);
    localparam logic signed [9:0]  KdS   = 10'(KD);
    localparam logic signed [10:0] BaseS = 11'(BASE_SPEED);
    localparam logic signed [10:0] SpanS = 11'(SPAN);
    localparam logic signed [10:0] NeutS = 11'(NEUTRAL);

    logic [4:0]        sync1_q, sync2_q, sample_q;
    logic [CntW-1:0]   frame_cnt_q;
    logic              wrap;
    steer_state_e      state_q, state_d;

    logic signed [3:0] err_q, err_prev_q, dec_err;
    logic              dec_lost;
    logic signed [4:0] d_q, dec_d;
    logic              last_neg_q, stop_q;
    logic [LcW-1:0]    lost_cnt_q, lost_inc;
    logic signed [9:0] corr_q, corr_d;
    logic signed [10:0] corr_ext, cmd_l, cmd_r, srv_l, srv_r;

    assign wrap = (frame_cnt_q == CntLast);

    line_err_decode u_decode (
        .pattern   (sample_q),
        .err_prev  (err_prev_q),
        .err       (dec_err),
        .lost_flag (dec_lost)
    );

    // Two-flop synchroniser for the asynchronous sensor bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sensors;
            sync2_q <= sync1_q;
        end
    end

    // Frame counter; held at zero while idle so a frame starts fresh on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (!enable || state_q == StIdle || wrap) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one pass of decode/multiply/apply per frame wrap.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StWait;
                StWait:   state_d = wrap ? StDecode : StWait;
                StDecode: state_d = StMult;
                StMult:   state_d = StApply;
                StApply:  state_d = StWait;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Arithmetic helpers: derivative, lost-count increment, gain products and clamp.
    always_comb begin
        dec_d    = {dec_err[3], dec_err} - {err_prev_q[3], err_prev_q};
        lost_inc = (lost_cnt_q == LcSat) ? lost_cnt_q : lost_cnt_q + 1'b1;
        corr_d   = KpS * {{6{err_q[3]}}, err_q} + KdS * {{5{d_q[4]}}, d_q};
        corr_ext = {corr_q[9], corr_q};
        cmd_l    = clamp_span(BaseS + corr_ext, SpanS);
        cmd_r    = clamp_span(BaseS - corr_ext, SpanS);
        srv_l    = NeutS + cmd_l;
        srv_r    = NeutS - cmd_r;  // right servo is mounted mirrored
    end

    // Control datapath: sample, decode, multiply and apply stages plus lost handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q   <= '0;
            err_q      <= '0;
            err_prev_q <= '0;
            d_q        <= '0;
            corr_q     <= '0;
            last_neg_q <= 1'b0;
            stop_q     <= 1'b0;
            lost_cnt_q <= '0;
            servo_L    <= 8'(NEUTRAL);
            servo_R    <= 8'(NEUTRAL);
            frame_tick <= 1'b0;
            lost       <= 1'b0;
        end else if (!enable) begin
            err_q      <= '0;
            err_prev_q <= '0;
            d_q        <= '0;
            corr_q     <= '0;
            last_neg_q <= 1'b0;
            stop_q     <= 1'b0;
            lost_cnt_q <= '0;
            servo_L    <= 8'(NEUTRAL);
            servo_R    <= 8'(NEUTRAL);
            frame_tick <= 1'b0;
            lost       <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state_q)
                StWait: begin
                    if (wrap) begin
                        sample_q <= sync2_q;
                    end
                end
                StDecode: begin
                    if (dec_lost) begin
                        lost_cnt_q <= lost_inc;
                        d_q        <= '0;
                        if (lost_inc <= LcLimit) begin
                            // Search: keep turning toward the side the line was last seen.
                            err_q  <= last_neg_q ? -ERR_SEARCH : ERR_SEARCH;
                            stop_q <= 1'b0;
                        end else begin
                            err_q      <= '0;
                            err_prev_q <= '0;
                            stop_q     <= 1'b1;
                        end
                    end else begin
                        lost_cnt_q <= '0;
                        err_q      <= dec_err;
                        d_q        <= dec_d;
                        err_prev_q <= dec_err;
                        stop_q     <= 1'b0;
                        if (dec_err != 4'sd0) begin
                            last_neg_q <= dec_err[3];
                        end
                    end
                end
                StMult: begin
                    corr_q <= corr_d;
                end
                StApply: begin
                    frame_tick <= 1'b1;
                    lost       <= stop_q;
                    if (stop_q) begin
                        servo_L <= 8'(NEUTRAL);
                        servo_R <= 8'(NEUTRAL);
                    end else begin
                        servo_L <= srv_l[7:0];
                        servo_R <= srv_r[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Directed bench for line_steer_ctrl with a shortened 100-cycle frame.
module tb_line_steer_ctrl;

    localparam int unsigned FRAME = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] sensors;
    logic [7:0] servo_L;
    logic [7:0] servo_R;
    logic       frame_tick;
    logic       lost;

    int n_vec = 0;
    int n_bad = 0;
    int n;
    bit ok;

    line_steer_ctrl #(
        .FRAME_CYCLES (FRAME)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sensors    (sensors),
        .servo_L    (servo_L),
        .servo_R    (servo_R),
        .frame_tick (frame_tick),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges until frame_tick is seen (sampled 1 ns after each edge).
    task automatic wait_tick(input int budget, output int cnt, output bit seen);
        cnt  = 0;
        seen = 1'b0;
        while (cnt < budget && !seen) begin
            @(posedge clk);
            #1;
            cnt++;
            if (frame_tick === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic edges(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Waits one frame and checks the resulting servo words and lost flag.
    task automatic frame_chk(input string tag, input int exp_l, input int exp_r,
                             input bit exp_lost);
        wait_tick(FRAME + 50, n, ok);
        chk({tag, "_tick"}, 32'(ok), 32'd1);
        chk({tag, "_L"}, 32'(servo_L), 32'(exp_l));
        chk({tag, "_R"}, 32'(servo_R), 32'(exp_r));
        chk({tag, "_lost"}, 32'(lost), 32'(exp_lost));
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        sensors = 5'b00000;
        edges(3);
        chk("rst_L", 32'(servo_L), 32'd150);
        chk("rst_R", 32'(servo_R), 32'd150);
        chk("rst_lost", 32'(lost), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);

        // Idle with enable low: no updates at all.
        rst = 1'b0;
        wait_tick(150, n, ok);
        chk("idle_no_tick", 32'(ok), 32'd0);
        chk("idle_L", 32'(servo_L), 32'd150);

        // Centred run.
        sensors = 5'b00100;
        enable  = 1'b1;
        wait_tick(300, n, ok);
        chk("first_tick", 32'(ok), 32'd1);
        chk("first_latency_ge_frame", 32'(n >= int'(FRAME)), 32'd1);
        chk("ctr_L", 32'(servo_L), 32'd180);
        chk("ctr_R", 32'(servo_R), 32'd120);
        edges(1);
        chk("tick_one_cycle", 32'(frame_tick), 32'd0);
        wait_tick(FRAME + 50, n, ok);
        chk("frame_period", 32'(n), 32'(FRAME - 1));
        chk("ctr2_L", 32'(servo_L), 32'd180);
        chk("ctr2_R", 32'(servo_R), 32'd120);

        // Step right: err 4, d 4 then d 0.
        sensors = 5'b00001;
        frame_chk("step", 200, 168, 1'b0);
        frame_chk("step2", 200, 152, 1'b0);
        // Back to centre: err 0, d -4, corr -16.
        sensors = 5'b00100;
        frame_chk("back", 164, 104, 1'b0);
        frame_chk("back2", 180, 120, 1'b0);
        // Half step then adjacent pair.
        sensors = 5'b00010;
        frame_chk("half", 200, 144, 1'b0);
        sensors = 5'b00011;
        frame_chk("pair", 200, 148, 1'b0);
        sensors = 5'b00001;
        frame_chk("pre_lost", 200, 156, 1'b0);
        frame_chk("pre_lost2", 200, 152, 1'b0);

        // Line lost: 25 search frames, then a safe stop.
        sensors = 5'b00000;
        for (int f = 1; f <= 25; f++) begin
            frame_chk("search", 200, 152, 1'b0);
        end
        frame_chk("stop", 150, 150, 1'b1);
        frame_chk("stop_sat", 150, 150, 1'b1);
        sensors = 5'b00100;
        frame_chk("reacq", 180, 120, 1'b0);

        // Intersection and non-adjacent patterns hold the previous error.
        sensors = 5'b00001;
        frame_chk("hold_pre", 200, 168, 1'b0);
        sensors = 5'b11100;
        frame_chk("hold3", 200, 152, 1'b0);
        sensors = 5'b10001;
        frame_chk("hold_gap", 200, 152, 1'b0);

        // Hard left, then a left-side search, then recovery from err_prev -4.
        sensors = 5'b10000;
        frame_chk("left", 116, 100, 1'b0);
        sensors = 5'b00000;
        frame_chk("search_left", 148, 100, 1'b0);
        sensors = 5'b00100;
        frame_chk("recover", 196, 136, 1'b0);

        // Enable drop while the FSM is mid-computation.
        edges(98);
        enable = 1'b0;
        edges(2);
        chk("abort_en_L", 32'(servo_L), 32'd150);
        chk("abort_en_R", 32'(servo_R), 32'd150);
        wait_tick(150, n, ok);
        chk("abort_en_no_tick", 32'(ok), 32'd0);
        sensors = 5'b00001;
        enable  = 1'b1;
        wait_tick(300, n, ok);
        chk("reen_tick", 32'(ok), 32'd1);
        chk("reen_latency_ge_frame", 32'(n >= int'(FRAME)), 32'd1);
        chk("reen_L", 32'(servo_L), 32'd200);
        chk("reen_R", 32'(servo_R), 32'd168);

        // Reset pulse mid-computation.
        edges(98);
        rst = 1'b1;
        #1;
        chk("abort_rst_L", 32'(servo_L), 32'd150);
        chk("abort_rst_R", 32'(servo_R), 32'd150);
        chk("abort_rst_tick", 32'(frame_tick), 32'd0);
        edges(2);
        rst = 1'b0;
        wait_tick(300, n, ok);
        chk("rst_re_tick", 32'(ok), 32'd1);
        chk("rst_re_latency_ge_frame", 32'(n >= int'(FRAME)), 32'd1);
        chk("rst_re_L", 32'(servo_L), 32'd200);
        chk("rst_re_R", 32'(servo_R), 32'd168);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
